hilo_div_ctrl: RTL and testbench
================================

// Module: hilo_div_ctrl
// PURPOSE
//  EX-stage HI/LO owner for the MIPS core. It decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO
//  and launches the multi-cycle divider over a valid/div_stall handshake. It stalls
//  the pipeline while a divide is outstanding, then writes {remainder, quotient}
//  into HI/LO. It also serves MFHI/MFLO with bypass and guards divide-by-zero,
//  because the divider never terminates when the divisor is 0.
// PARAMETERS
//  MAX_DIV_CYC  80  BUSY cycles before div_timeout is raised (divider worst case ~67)
//  DIVZERO_KEEP 1   1: DIV/DIVU with rt==0 leaves HI/LO unchanged; 0: HI<=rs, LO<=32'hFFFFFFFF
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, asynchronous, active-high
//  ex_valid    in   1   EX-stage instruction valid
//  op_mult     in   1   MULT
//  op_multu    in   1   MULTU
//  op_div      in   1   DIV (signed)
//  op_divu     in   1   DIVU
//  op_mthi     in   1   MTHI
//  op_mtlo     in   1   MTLO
//  rs_data     in   32  rs operand (dividend / MTx source)
//  rt_data     in   32  rt operand (divisor)
//  mul_result  in   64  same-cycle product from the multiplier {hi,lo}
//  flush       in   1   cancel EX instruction (exception/eret)
//  stall_o     out  1   hold IF..EX this cycle
//  div_valid   out  1   start pulse to divider
//  div_sign    out  1   1: signed divide
//  div_a       out  32  dividend to divider
//  div_b       out  32  divisor to divider
//  div_stall   in   1   divider busy
//  div_result  in   64  {remainder, quotient} from divider
//  hi_o        out  32  HI value for MFHI, bypassed
//  lo_o        out  32  LO value for MFLO, bypassed
//  div_timeout out  1   sticky: BUSY exceeded MAX_DIV_CYC
// BEHAVIOUR
//  Reset: state=IDLE, HI=LO=0, div_valid=0, div_sign=0, div_a=div_b=0,
//   stall_o=0, div_timeout=0, cnt=0.
//  Accept: go = ex_valid & ~flush & ~stall_o.
//  FSM states IDLE -> LAUNCH -> BUSY -> IDLE.
//  IDLE:
//   - go & (op_div|op_divu) & rt_data!=0: latch a=rs_data, b=rt_data, sign=op_div.
//     Go to LAUNCH. stall_o=1 combinationally this cycle.
//   - go & (op_div|op_divu) & rt_data==0: no launch, no stall.
//     Handle HI/LO per DIVZERO_KEEP at the clock edge.
//   - go & op_mult|op_multu: HI<=mul_result[63:32], LO<=mul_result[31:0].
//   - go & op_mthi: HI<=rs_data. go & op_mtlo: LO<=rs_data.
//  LAUNCH (1 cycle): div_valid=1 and div_a/div_b/div_sign driven from the latches.
//   stall_o=1. Next state BUSY. The divider samples at this edge and raises div_stall.
//  BUSY: div_valid=0; cnt increments each cycle.
//   - div_stall=1: stall_o=1, stay in BUSY.
//   - div_stall=0: result valid this cycle. Unless cancelled,
//     HI<=div_result[63:32], LO<=div_result[31:0]. stall_o=0 this cycle,
//     so the pipeline advances at the same edge. Next state IDLE; cnt<=0.
//  div_valid is never asserted outside LAUNCH. Exactly one pulse per divide;
//   the divider ignores valid while busy.
//  Flush in LAUNCH/BUSY: set a cancel flag. The divide cannot be aborted, so stay
//   in BUSY until div_stall=0, then discard the result (HI/LO unchanged).
//   stall_o stays asserted until then. Cancel clears on return to IDLE.
//  Flush in IDLE blocks every HI/LO write that cycle.
//  cnt reaching MAX_DIV_CYC sets div_timeout (sticky until rst). The FSM keeps waiting.
//  hi_o/lo_o bypass: while go & (op_mult|op_multu|op_mthi|op_mtlo) is active in
//   IDLE, they show the value being written this cycle; otherwise the registers.
//  Simultaneous MTHI and MTLO asserted: both write.
//   Op one-hot violation is undefined (not checked).
//  Async rst mid-divide returns to IDLE. The divider shares rst, so no orphan
//   div_stall remains.
// TESTING
//  DIVU rs=100 rt=7 -> one div_valid pulse, stall until div_stall falls; HI=2 LO=14.
//  DIV rs=-7 rt=2 -> div_sign=1; HI=32'hFFFFFFFF LO=32'hFFFFFFFD.
//  DIV rt=0, DIVZERO_KEEP=1, HI=5 LO=9 -> no div_valid, stall_o=0; HI=5 LO=9 after.
//  DIVU 0xFFFFFFFF/1, flush asserted in 3rd BUSY cycle -> stall until done; HI/LO unchanged.
//  MTHI 0x1234 then MULTU with mul_result=64'hA_0000000B -> hi_o=0x1234, then HI=0xA LO=0xB.
//  Forced div_stall held 100 cycles -> div_timeout=1 at BUSY cycle 80, stays 1; rst clears it.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_div_ctrl
//   EX-stage owner of the HI/LO register pair.
//   - MULT/MULTU: HI/LO take the same-cycle product from the multiplier.
//   - MTHI/MTLO:  HI or LO takes rs_data. Both may be asserted together.
//   - DIV/DIVU:   launches the multi-cycle divider with a one-cycle start pulse.
//                 The pipeline stalls until the divider finishes. HI/LO then take
//                 {remainder, quotient}. A divisor of zero never reaches the
//                 divider, because the divider would never finish.
//   - MFHI/MFLO:  hi_o/lo_o show the register values. When a multiply or move
//                 is writing HI/LO in the same cycle, they show the new value.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   ex_valid, flush          EX instruction valid / cancel it
//   op_*                     one-hot operation decode
//   rs_data, rt_data         operands
//   mul_result               {hi, lo} product from the multiplier
//   stall_o                  hold IF..EX this cycle
//   div_valid, div_sign,
//   div_a, div_b             divider start handshake and operands
//   div_stall, div_result    divider busy flag and {remainder, quotient}
//   hi_o, lo_o               bypassed HI/LO read values
//   div_timeout              sticky: a divide stayed busy for MAX_DIV_CYC cycles
// -----------------------------------------------------------------------------
module hilo_div_ctrl #(
  parameter int MAX_DIV_CYC  = 80,
  parameter bit DIVZERO_KEEP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        op_mult,
  input  logic        op_multu,
  input  logic        op_div,
  input  logic        op_divu,
  input  logic        op_mthi,
  input  logic        op_mtlo,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [63:0] mul_result,
  input  logic        flush,
  output logic        stall_o,
  output logic        div_valid,
  output logic        div_sign,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_stall,
  input  logic [63:0] div_result,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_timeout
);

  localparam int CW = $clog2(MAX_DIV_CYC + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;

  state_t          state, state_d;
  logic [31:0]     hi_q, lo_q, hi_d, lo_d;
  logic [31:0]     a_q, b_q;
  logic            sign_q;
  logic            cancel_q, cancel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            latch_en;
  logic            bypass;
  logic            go;
  logic            is_div;

  // A new instruction is accepted only in IDLE. The stall raised by the
  // divide being accepted must not gate its own acceptance, so the other
  // terms of stall_o are folded into the state test rather than into stall_o.
  assign go     = ex_valid & ~flush & (state == IDLE);
  assign is_div = op_div | op_divu;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cancel_d  = cancel_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    stall_o   = 1'b0;
    latch_en  = 1'b0;
    bypass    = 1'b0;

    unique case (state)
      IDLE: begin
        cancel_d = 1'b0;
        cnt_d    = '0;
        if (go) begin
          if (is_div) begin
            if (rt_data != 32'd0) begin
              latch_en = 1'b1;
              stall_o  = 1'b1;
              state_d  = LAUNCH;
            end else if (!DIVZERO_KEEP) begin
              hi_d = rs_data;
              lo_d = 32'hFFFF_FFFF;
            end
          end
          if (op_mult | op_multu) begin
            hi_d   = mul_result[63:32];
            lo_d   = mul_result[31:0];
            bypass = 1'b1;
          end
          if (op_mthi) begin
            hi_d   = rs_data;
            bypass = 1'b1;
          end
          if (op_mtlo) begin
            lo_d   = rs_data;
            bypass = 1'b1;
          end
        end
      end

      LAUNCH: begin
        stall_o = 1'b1;
        state_d = BUSY;
        if (flush) cancel_d = 1'b1;
      end

      BUSY: begin
        if (flush) cancel_d = 1'b1;
        // Saturate so a divider that hangs cannot wrap the count.
        if (cnt_q != CW'(MAX_DIV_CYC)) cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MAX_DIV_CYC - 1)) timeout_d = 1'b1;
        if (div_stall) begin
          stall_o = 1'b1;
        end else begin
          // Result is valid now; the pipeline advances at this same edge.
          state_d = IDLE;
          cnt_d   = '0;
          if (!(cancel_q | flush)) begin
            hi_d = div_result[63:32];
            lo_d = div_result[31:0];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      cancel_q  <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cancel_q  <= cancel_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      if (latch_en) begin
        a_q    <= rs_data;
        b_q    <= rt_data;
        sign_q <= op_div;
      end
    end
  end

  assign div_valid   = (state == LAUNCH);
  assign div_a       = a_q;
  assign div_b       = b_q;
  assign div_sign    = sign_q;
  assign div_timeout = timeout_q;
  assign hi_o        = bypass ? hi_d : hi_q;
  assign lo_o        = bypass ? lo_d : lo_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_div_ctrl
//   Drives one EX instruction at a time, with one idle cycle after each.
//   A behavioural divider model answers the start pulse after a chosen latency.
//   The driver pushes the expected HI/LO state and divider handshake of every
//   instruction into a scoreboard queue. A negedge monitor pops an entry each
//   time an instruction leaves EX and compares the DUT against it.
// -----------------------------------------------------------------------------
module tb_hilo_div_ctrl;

  localparam int MAX_CYC = 80;
  localparam bit KEEP    = 1'b1;

  logic        clk, rst;
  logic        ex_valid, op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
  logic [31:0] rs_data, rt_data;
  logic [63:0] mul_result;
  logic        flush;
  logic        stall_o, div_valid, div_sign;
  logic [31:0] div_a, div_b;
  logic        div_stall;
  logic [63:0] div_result;
  logic [31:0] hi_o, lo_o;
  logic        div_timeout;

  hilo_div_ctrl #(.MAX_DIV_CYC(MAX_CYC), .DIVZERO_KEEP(KEEP)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid),
    .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
    .op_mthi(op_mthi), .op_mtlo(op_mtlo),
    .rs_data(rs_data), .rt_data(rt_data), .mul_result(mul_result), .flush(flush),
    .stall_o(stall_o), .div_valid(div_valid), .div_sign(div_sign),
    .div_a(div_a), .div_b(div_b), .div_stall(div_stall), .div_result(div_result),
    .hi_o(hi_o), .lo_o(lo_o), .div_timeout(div_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef enum int {OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MTBOTH} op_e;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    bit          bypass;
    int          pulses;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi, m_lo;

  // MIPS divide: quotient truncates toward zero, remainder takes the dividend's sign.
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint q, r;
    if (s) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'(a) / longint'(b);
      r = longint'(a) % longint'(b);
    end
    return {r[31:0], q[31:0]};
  endfunction

  // ---------------- divider model ----------------
  int   bfm_lat = 1;
  bit   force_hold = 1'b0;
  logic bfm_busy;
  int   bfm_rem;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bfm_busy   <= 1'b0;
      div_stall  <= 1'b0;
      div_result <= '0;
      bfm_rem    <= 0;
    end else if (!bfm_busy) begin
      if (div_valid) begin
        bfm_busy   <= 1'b1;
        div_stall  <= 1'b1;
        bfm_rem    <= bfm_lat;
        div_result <= div_ref(div_a, div_b, div_sign);
      end
    end else if (div_stall) begin
      if (!force_hold) begin
        if (bfm_rem <= 1) div_stall <= 1'b0;
        else              bfm_rem   <= bfm_rem - 1;
      end
    end else begin
      bfm_busy <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  int   pulse_cnt = 0;
  bit   pending = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst) begin
      if (pending) begin
        check("hi_reg", hi_o, cur.hi);
        check("lo_reg", lo_o, cur.lo);
        pending = 1'b0;
      end
      if (div_valid) begin
        pulse_cnt++;
        if (sb_q.size() > 0) begin
          check("div_sign", div_sign, sb_q[0].sign);
          check("div_a", div_a, sb_q[0].a);
          check("div_b", div_b, sb_q[0].b);
        end else begin
          check("pulse_without_instr", sb_q.size(), 1);
        end
      end
      if (ex_valid && !stall_o) begin
        if (sb_q.size() == 0) begin
          check("retire_without_expect", sb_q.size(), 1);
        end else begin
          cur = sb_q.pop_front();
          check("div_pulses", pulse_cnt, cur.pulses);
          pulse_cnt = 0;
          if (cur.bypass) begin
            check("hi_bypass", hi_o, cur.hi);
            check("lo_bypass", lo_o, cur.lo);
          end
          pending = 1'b1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input op_e op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [63:0] mul, input bit flush0, input int flush_at,
                       input int lat, input bit chk_to, output int cyc);
    exp_t        e;
    logic [63:0] r;
    bit          done;
    e.bypass = 1'b0;
    e.pulses = 0;
    e.sign   = (op == OP_DIV);
    e.a      = rs;
    e.b      = rt;
    if (!flush0) begin
      case (op)
        OP_MULT, OP_MULTU: begin m_hi = mul[63:32]; m_lo = mul[31:0]; e.bypass = 1'b1; end
        OP_MTHI:   begin m_hi = rs; e.bypass = 1'b1; end
        OP_MTLO:   begin m_lo = rs; e.bypass = 1'b1; end
        OP_MTBOTH: begin m_hi = rs; m_lo = rs; e.bypass = 1'b1; end
        OP_DIV, OP_DIVU: begin
          if (rt == 32'd0) begin
            if (!KEEP) begin m_hi = rs; m_lo = 32'hFFFF_FFFF; end
          end else begin
            e.pulses = 1;
            if (flush_at == 0) begin
              r    = div_ref(rs, rt, op == OP_DIV);
              m_hi = r[63:32];
              m_lo = r[31:0];
            end
          end
        end
        default: ;
      endcase
    end
    e.hi = m_hi;
    e.lo = m_lo;
    sb_q.push_back(e);

    @(posedge clk); #1;
    ex_valid   = 1'b1;
    op_mult    = (op == OP_MULT);
    op_multu   = (op == OP_MULTU);
    op_div     = (op == OP_DIV);
    op_divu    = (op == OP_DIVU);
    op_mthi    = (op == OP_MTHI) || (op == OP_MTBOTH);
    op_mtlo    = (op == OP_MTLO) || (op == OP_MTBOTH);
    rs_data    = rs;
    rt_data    = rt;
    mul_result = mul;
    flush      = flush0;
    bfm_lat    = lat;

    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      if (chk_to) begin
        if (cyc == MAX_CYC + 1) check("timeout_before", div_timeout, 1'b0);
        if (cyc == MAX_CYC + 2) check("timeout_at_limit", div_timeout, 1'b1);
        if (cyc == 101) begin
          check("timeout_held", div_timeout, 1'b1);
          force_hold = 1'b0;
        end
      end
      if (!stall_o) begin
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        flush = (flush_at != 0) && (cyc == flush_at);
      end
    end
    check("retire_within_budget", done, 1'b1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    op_mult = 0; op_multu = 0; op_div = 0; op_divu = 0; op_mthi = 0; op_mtlo = 0;
    flush = 1'b0;
  endtask

  initial begin
    int cyc;
    ex_valid = 0; op_mult = 0; op_multu = 0; op_div = 0; op_divu = 0;
    op_mthi = 0; op_mtlo = 0; rs_data = 0; rt_data = 0; mul_result = 0; flush = 0;
    m_hi = 0; m_lo = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_stall", stall_o, 1'b0);
    check("rst_div_valid", div_valid, 1'b0);
    check("rst_div_sign", div_sign, 1'b0);
    check("rst_div_a", div_a, 32'd0);
    check("rst_div_b", div_b, 32'd0);
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    check("rst_timeout", div_timeout, 1'b0);

    // DIVU 100/7 with a 5-cycle divider: accept, launch, 5 busy, done.
    issue(OP_DIVU, 32'd100, 32'd7, 64'd0, 1'b0, 0, 5, 1'b0, cyc);
    check("divu_stall_cycles", cyc, 7);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'd0, 1'b0, 0, 3, 1'b0, cyc);
    // Divide by zero with HI=5 LO=9.
    issue(OP_MTHI, 32'd5, 32'd0, 64'd0, 1'b0, 0, 1, 1'b0, cyc);
    issue(OP_MTLO, 32'd9, 32'd0, 64'd0, 1'b0, 0, 1, 1'b0, cyc);
    issue(OP_DIV, 32'd1234, 32'd0, 64'd0, 1'b0, 0, 1, 1'b0, cyc);
    check("divzero_no_stall", cyc, 0);
    // Flush in the third busy cycle: still stalls until done, result dropped.
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 64'd0, 1'b0, 4, 8, 1'b0, cyc);
    check("flushed_div_stall_cycles", cyc, 10);
    issue(OP_MTHI, 32'h1234, 32'd0, 64'd0, 1'b0, 0, 1, 1'b0, cyc);
    issue(OP_MULTU, 32'd0, 32'd0, 64'h0000_000A_0000_000B, 1'b0, 0, 1, 1'b0, cyc);
    issue(OP_MTBOTH, 32'hCAFE_F00D, 32'd0, 64'd0, 1'b0, 0, 1, 1'b0, cyc);
    // Flush in IDLE blocks the write.
    issue(OP_MULT, 32'd0, 32'd0, 64'h1111_2222_3333_4444, 1'b1, 0, 1, 1'b0, cyc);

    // Divider held busy ~100 cycles: sticky timeout, cleared only by reset.
    force_hold = 1'b1;
    issue(OP_DIVU, 32'd50, 32'd3, 64'd0, 1'b0, 0, 2, 1'b1, cyc);
    @(negedge clk);
    check("timeout_sticky", div_timeout, 1'b1);
    #1 rst = 1'b1;
    m_hi = 0; m_lo = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("timeout_cleared", div_timeout, 1'b0);
    check("hi_after_rst", hi_o, 32'd0);
    check("lo_after_rst", lo_o, 32'd0);

    for (int i = 0; i < 60; i++) begin
      op_e         op;
      logic [31:0] rs, rt;
      logic [63:0] mul;
      bit          fl;
      int          lat, fat;
      op  = op_e'($urandom_range(0, 7));
      rs  = $urandom;
      rt  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      mul = {$urandom, $urandom};
      fl  = ($urandom_range(0, 9) == 0);
      lat = $urandom_range(1, 12);
      fat = 0;
      if ((op == OP_DIV || op == OP_DIVU) && !fl && $urandom_range(0, 3) == 0)
        fat = $urandom_range(1, lat + 1);
      issue(op, rs, rt, mul, fl, fat, lat, 1'b0, cyc);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
